// File: rtl/alu_writeback_if.sv
// ALU result input and register-file writeback bus; the slave modport is the writeback stage's view,
// the master modport is the view of whatever drives the results and consumes the beats.
interface alu_writeback_if #(
   parameter int DEST_W = 4
);
   logic              iValid;
   logic              oReady;
   logic [31:0]       iHi;
   logic [31:0]       iLo;
   logic              iZero;
   logic              iNeg;
   logic              iWide;
   logic [DEST_W-1:0] iDest;
   logic              oValid;
   logic              iReady;
   logic [31:0]       oData;
   logic [DEST_W-1:0] oDest;
   logic              oHiBeat;
   logic              oZ;
   logic              oN;

   modport slave (
      input  iValid, iHi, iLo, iZero, iNeg, iWide, iDest, iReady,
      output oReady, oValid, oData, oDest, oHiBeat, oZ, oN
   );

   modport master (
      output iValid, iHi, iLo, iZero, iNeg, iWide, iDest, iReady,
      input  oReady, oValid, oData, oDest, oHiBeat, oZ, oN
   );
endinterface

// File: rtl/alu_writeback.sv
// ALU writeback: 1 cycle from accept to first beat, one beat (LO) or two (LO then HI) for wide results.
// Stalls while iReady=0; a new result can be taken on the edge where the final beat completes.
module alu_writeback #(
   parameter int DEST_W = 4
) (
   input  logic            iClk,
   input  logic            nRst,
   alu_writeback_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

   state_t            state_q, state_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;
   logic              wide_q, wide_d;
   logic [DEST_W-1:0] dest_q, dest_d;
   logic              z_q, z_d;
   logic              n_q, n_d;
   logic              ready;
   logic              accept;

   // oReady looks only at state and iReady so there is no iValid -> oReady path
   always_comb begin
      ready  = 1'b0;
      accept = 1'b0;
      case (state_q)
         S_IDLE:  ready = 1'b1;
         S_LO:    ready = !wide_q && bus.iReady;
         S_HI:    ready = bus.iReady;
         default: ready = 1'b0;
      endcase
      accept = bus.iValid && ready;
   end

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      wide_d  = wide_q;
      dest_d  = dest_q;
      z_d     = z_q;
      n_d     = n_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_LO;
         S_LO: begin
            if (bus.iReady) begin
               if (wide_q)      state_d = S_HI;
               else if (accept) state_d = S_LO;
               else             state_d = S_IDLE;
            end
         end
         S_HI: begin
            if (bus.iReady) state_d = accept ? S_LO : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         hi_d   = bus.iHi;
         lo_d   = bus.iLo;
         wide_d = bus.iWide;
         dest_d = bus.iDest;
         z_d    = bus.iZero;
         n_d    = bus.iNeg;
      end
   end

   always_ff @(posedge iClk or negedge nRst) begin
      if (!nRst) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         wide_q  <= 1'b0;
         dest_q  <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         wide_q  <= wide_d;
         dest_q  <= dest_d;
         z_q     <= z_d;
         n_q     <= n_d;
      end
   end

   // Beat outputs decode straight from state, so reset clears them without waiting for a clock
   always_comb begin
      bus.oValid  = 1'b0;
      bus.oData   = '0;
      bus.oDest   = '0;
      bus.oHiBeat = 1'b0;
      case (state_q)
         S_LO: begin
            bus.oValid = 1'b1;
            bus.oData  = lo_q;
            bus.oDest  = dest_q;
         end
         S_HI: begin
            bus.oValid  = 1'b1;
            bus.oData   = hi_q;
            bus.oDest   = dest_q;
            bus.oHiBeat = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.oReady = ready;
   assign bus.oZ     = z_q;
   assign bus.oN     = n_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: inputs change just after the falling edge, outputs are checked 1ns later.
module tb_alu_writeback;

   logic iClk = 1'b0;
   logic nRst = 1'b0;
   int   n_assert = 0;
   int   n_fail = 0;
   int   beat_cnt = 0;
   int   beat_snap;

   alu_writeback_if #(.DEST_W(4)) bus ();

   alu_writeback #(.DEST_W(4)) dut (
      .iClk (iClk),
      .nRst (nRst),
      .bus  (bus)
   );

   always #5 iClk = ~iClk;

   always @(posedge iClk) if (bus.oValid && bus.iReady) beat_cnt <= beat_cnt + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] hi, input logic [31:0] lo,
                        input logic z, input logic n, input logic w,
                        input logic [3:0] d, input logic rdy);
      @(negedge iClk);
      bus.iValid = v;
      bus.iHi    = hi;
      bus.iLo    = lo;
      bus.iZero  = z;
      bus.iNeg   = n;
      bus.iWide  = w;
      bus.iDest  = d;
      bus.iReady = rdy;
      #1;
   endtask

   task automatic chk_beat(input string tag, input logic v, input logic [31:0] dat,
                           input logic [3:0] d, input logic hb);
      chk({tag, "_valid"}, 64'(bus.oValid), 64'(v));
      chk({tag, "_data"},  64'(bus.oData),  64'(dat));
      chk({tag, "_dest"},  64'(bus.oDest),  64'(d));
      chk({tag, "_hibeat"}, 64'(bus.oHiBeat), 64'(hb));
   endtask

   initial begin
      bus.iValid = 1'b0; bus.iHi = '0; bus.iLo = '0; bus.iZero = 1'b0;
      bus.iNeg = 1'b0; bus.iWide = 1'b0; bus.iDest = '0; bus.iReady = 1'b1;
      #2;
      // Reset state
      chk_beat("rst", 1'b0, 32'h0, 4'h0, 1'b0);
      chk("rst_z", 64'(bus.oZ), 64'd0);
      chk("rst_n", 64'(bus.oN), 64'd0);
      chk("rst_ready", 64'(bus.oReady), 64'd1);
      @(negedge iClk); nRst = 1'b1;

      // ADD single-word result
      drive(1'b1, 32'h0, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1);
      chk("add_idle_ready", 64'(bus.oReady), 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk_beat("add_beat", 1'b1, 32'h5, 4'd3, 1'b0);
      chk("add_ready_final", 64'(bus.oReady), 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk_beat("add_idle", 1'b0, 32'h0, 4'd0, 1'b0);
      chk("add_z", 64'(bus.oZ), 64'd0);
      chk("add_n", 64'(bus.oN), 64'd0);

      // MUL wide result
      drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk_beat("mul_lo", 1'b1, 32'hFFFF_FFFE, 4'd5, 1'b0);
      chk("mul_lo_ready", 64'(bus.oReady), 64'd0);
      chk("mul_n", 64'(bus.oN), 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk_beat("mul_hi", 1'b1, 32'hFFFF_FFFF, 4'd5, 1'b1);
      chk("mul_hi_ready", 64'(bus.oReady), 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("mul_done", 64'(bus.oValid), 64'd0);

      // Backpressure, with differing input offered while stalled
      drive(1'b1, 32'hA1A1_A1A1, 32'hA0A0_A0A0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
      beat_snap = beat_cnt;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'hB1B1_B1B1, 32'hB0B0_B0B0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0);
         chk_beat("bp_lo_stall", 1'b1, 32'hA0A0_A0A0, 4'd7, 1'b0);
         chk("bp_lo_ready", 64'(bus.oReady), 64'd0);
         chk("bp_lo_z", 64'(bus.oZ), 64'd0);
      end
      drive(1'b1, 32'hB1B1_B1B1, 32'hB0B0_B0B0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1);
      chk_beat("bp_lo_go", 1'b1, 32'hA0A0_A0A0, 4'd7, 1'b0);
      chk("bp_lo_go_ready", 64'(bus.oReady), 64'd0);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'hB1B1_B1B1, 32'hB0B0_B0B0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0);
         chk_beat("bp_hi_stall", 1'b1, 32'hA1A1_A1A1, 4'd7, 1'b1);
         chk("bp_hi_ready", 64'(bus.oReady), 64'd0);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk_beat("bp_hi_go", 1'b1, 32'hA1A1_A1A1, 4'd7, 1'b1);
      chk("bp_hi_go_ready", 64'(bus.oReady), 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("bp_beats", 64'(beat_cnt - beat_snap), 64'd2);
      chk("bp_idle", 64'(bus.oValid), 64'd0);
      chk("bp_z_kept", 64'(bus.oZ), 64'd0);

      // Back-to-back single-word results
      drive(1'b1, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
      drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1);
      chk_beat("b2b_first", 1'b1, 32'h1, 4'd1, 1'b0);
      chk("b2b_ready", 64'(bus.oReady), 64'd1);
      chk("b2b_z0", 64'(bus.oZ), 64'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk_beat("b2b_second", 1'b1, 32'h0, 4'd2, 1'b0);
      chk("b2b_z1", 64'(bus.oZ), 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk("b2b_idle", 64'(bus.oValid), 64'd0);

      // Reset while the HI beat is pending
      drive(1'b1, 32'hC1C1_C1C1, 32'hC0C0_C0C0, 1'b1, 1'b1, 1'b1, 4'd4, 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk_beat("rhi_lo", 1'b1, 32'hC0C0_C0C0, 4'd4, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
      chk_beat("rhi_hi", 1'b1, 32'hC1C1_C1C1, 4'd4, 1'b1);
      nRst = 1'b0;
      #1;
      chk_beat("rhi_rst", 1'b0, 32'h0, 4'd0, 1'b0);
      chk("rhi_z", 64'(bus.oZ), 64'd0);
      chk("rhi_n", 64'(bus.oN), 64'd0);
      @(negedge iClk); nRst = 1'b1; bus.iReady = 1'b1;
      beat_snap = beat_cnt;
      repeat (3) @(negedge iClk);
      #1;
      chk("rhi_no_beat", 64'(beat_cnt - beat_snap), 64'd0);
      chk("rhi_idle", 64'(bus.oValid), 64'd0);

      // First accept straight after reset release
      @(negedge iClk); nRst = 1'b0;
      @(negedge iClk); nRst = 1'b1;
      bus.iValid = 1'b1; bus.iLo = 32'h9; bus.iDest = 4'd6; bus.iWide = 1'b0;
      #1;
      chk("post_rst_ready", 64'(bus.oReady), 64'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      chk_beat("post_rst_beat", 1'b1, 32'h9, 4'd6, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter DEST_W, default 4, width of the destination register index.
REQ-002 iClk  input  1  system clock; all state changes on rising edge.
REQ-003 nRst  input  1  asynchronous active-low reset.
REQ-004 iValid  input  1  ALU result present on iHi/iLo/iZero/iNeg/iWide/iDest.
REQ-005 oReady  output  1  stage can accept a result this cycle.
REQ-006 iHi, iLo  input  32 each  ALU high/low result words (MUL product high/low; DIV quotient/remainder).
REQ-007 iZero, iNeg  input  1 each  ALU zero/negative flags.
REQ-008 iWide  input  1  result is 64-bit (MUL/DIV); two writeback beats required.
REQ-009 iDest  input  DEST_W  destination register index for the low beat.
REQ-010 oValid  output  1  writeback beat present on oData/oDest/oHiBeat.
REQ-011 iReady  input  1  register file/bus consumes the beat this cycle.
REQ-012 oData  output  32  writeback data.
REQ-013 oDest  output  DEST_W  destination index of the current beat.
REQ-014 oHiBeat  output  1  1 = beat targets HI register, 0 = LO/GPR target.
REQ-015 oZ, oN  output  1 each  condition-code register.

Function
REQ-016 Block SHALL implement FSM states IDLE, LO, HI.
REQ-017 A transfer in SHALL occur on a rising edge where iValid && oReady; a beat out SHALL complete where oValid && iReady.
REQ-018 oReady SHALL be 1 in IDLE, 1 in the final beat (LO with stored wide=0, or HI) when iReady=1, else 0 (combinational from state and iReady only; no path from iValid).
REQ-019 On transfer in, block SHALL latch iHi, iLo, iWide, iDest into holding registers and enter LO.
REQ-020 On transfer in, oZ/oN SHALL load iZero/iNeg; they SHALL otherwise hold.
REQ-021 In LO: oValid=1, oData=held lo, oDest=held dest, oHiBeat=0.
REQ-022 In HI: oValid=1, oData=held hi, oDest=held dest, oHiBeat=1.
REQ-023 In IDLE: oValid=0, oData=0, oDest=0, oHiBeat=0.
REQ-024 LO with iReady=0 or HI with iReady=0 SHALL hold state and all outputs stable.
REQ-025 LO, iReady=1, wide=1 SHALL go to HI; no new transfer in on that edge (oReady=0).
REQ-026 Final beat completing with iValid=1 SHALL accept the new result on the same edge and go to LO (zero-bubble back-to-back).
REQ-027 Final beat completing with iValid=0 SHALL go to IDLE.
REQ-028 Single-word result SHALL take 1 beat minimum, wide result 2 beats minimum; latency iValid accept to first oValid = 1 cycle.
REQ-029 Inputs while oReady=0 SHALL be ignored; upstream holds iValid and data until accepted.
REQ-030 No data width conversion: oData SHALL equal the held word bit-exact.

Reset
REQ-031 nRst low SHALL asynchronously force state IDLE, holding registers 0, oZ=0, oN=0, oValid=0, oData=0, oDest=0, oHiBeat=0.
REQ-032 nRst asserted mid-operation (LO or HI) SHALL drop the in-flight result with no further beats.
REQ-033 After nRst release, first accept SHALL be possible on the first rising edge with iValid=1.

Verification
REQ-034 ADD result: iLo=0x0000_0005, iWide=0, iDest=3, iZero=0, iNeg=0, iReady=1 -> one beat oData=0x5, oDest=3, oHiBeat=0; then IDLE, oZ=0, oN=0.
REQ-035 MUL result: iHi=0xFFFF_FFFF, iLo=0xFFFF_FFFE, iWide=1, iNeg=1, iReady=1 -> beat 1 oData=0xFFFF_FFFE oHiBeat=0, beat 2 oData=0xFFFF_FFFF oHiBeat=1; oN=1; oReady=0 during beat 1.
REQ-036 Backpressure: wide result, iReady=0 for 3 cycles in LO then 2 cycles in HI -> outputs stable each stalled cycle, exactly 2 beats delivered, oReady=0 throughout stalls.
REQ-037 Back-to-back: two single-word results (0x1 dest 1, 0x0 dest 2, iZero=1) with iValid held and iReady=1 -> beats on consecutive cycles, no bubble, oZ=1 after second accept.
REQ-038 Reset mid-HI: wide result, nRst pulsed low while in HI -> oValid=0 immediately, oZ=oN=0, no HI beat after release.
REQ-039 Ignored input: iValid=1 with differing data while in LO stalled -> held data unchanged, input accepted only when oReady=1.
